// File: rtl/lsu_tcm_responder_pkg.sv
// Shared LSU request/ack types, AMO encodings and access-size constants
// for the tightly-coupled memory responder.
package lsu_tcm_responder_pkg;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_SWAP = 4'd1,
        AMO_ADD  = 4'd2,
        AMO_AND  = 4'd3,
        AMO_OR   = 4'd4,
        AMO_XOR  = 4'd5,
        AMO_MIN  = 4'd6,
        AMO_MAX  = 4'd7,
        AMO_MINU = 4'd8,
        AMO_MAXU = 4'd9
    } lsu_amo_e;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  amo;
        logic [3:0]  strb;
        logic [1:0]  size;
    } lsu_req_t;

    typedef struct packed {
        logic        ack;
        logic        error;
        logic [31:0] rdata;
    } lsu_ack_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESP    = 2'd1,
        ST_AMO_WR  = 2'd2,
        ST_AMO_ACK = 2'd3
    } tcm_state_e;

    // The amo field is raw bits so undefined encodings can be detected
    function automatic logic amo_known(input logic [3:0] code);
        return code <= 4'(AMO_MAXU);
    endfunction

endpackage

// File: rtl/lsu_tcm_responder_amo_alu.sv
// Combinational read-modify-write datapath for word atomics.
// Produces the value written back given the old memory word and the operand.
module lsu_amo_alu
    import lsu_tcm_responder_pkg::*;
(
    input  lsu_amo_e    op,
    input  logic [31:0] old_val,
    input  logic [31:0] operand,
    output logic [31:0] result
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(old_val) < $signed(operand);
    assign lt_u = old_val < operand;

    always_comb begin
        result = old_val;
        case (op)
            AMO_SWAP: result = operand;
            AMO_ADD:  result = old_val + operand;
            AMO_AND:  result = old_val & operand;
            AMO_OR:   result = old_val | operand;
            AMO_XOR:  result = old_val ^ operand;
            AMO_MIN:  result = lt_s ? old_val : operand;
            AMO_MAX:  result = lt_s ? operand : old_val;
            AMO_MINU: result = lt_u ? old_val : operand;
            AMO_MAXU: result = lt_u ? operand : old_val;
            default:  result = old_val;
        endcase
    end

endmodule

// File: rtl/lsu_tcm_responder.sv
// Serves one LSU request channel from a single-port word TCM,
// including byte/half/word stores and read-modify-write word AMOs.
module lsu_tcm_responder
    import lsu_tcm_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h10000,
    parameter int          DEPTH     = 4096,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  lsu_req_t      lsu_req_i,
    output lsu_ack_t      lsu_ack_o,
    output logic          sram_en_o,
    output logic          sram_we_o,
    output logic [3:0]    sram_be_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i
);

    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    tcm_state_e    state;
    logic          err_q;
    logic          load_q;
    lsu_amo_e      amo_q;
    logic [31:0]   wdata_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   old_q;

    logic [31:0]   offset;
    logic [AW-1:0] word_addr;
    logic          out_of_range;
    logic          misaligned;
    logic          amo_bad;
    logic          req_err;
    logic          is_amo;
    logic [31:0]   amo_result;

    // Addresses below the base wrap to a huge offset and fail the range test
    assign offset       = lsu_req_i.addr - BASE_ADDR;
    assign word_addr    = offset[AW+1:2];
    assign out_of_range = offset >= SPAN;
    assign is_amo       = lsu_req_i.amo != 4'(AMO_NONE);

    always_comb begin
        misaligned = 1'b0;
        unique case (1'b1)
            lsu_req_i.size == LSU_SIZE_B: misaligned = 1'b0;
            lsu_req_i.size == LSU_SIZE_H: misaligned = lsu_req_i.addr[0];
            lsu_req_i.size == LSU_SIZE_W: misaligned = |lsu_req_i.addr[1:0];
            default:                      misaligned = 1'b1;
        endcase
    end

    assign amo_bad = is_amo &&
                     (lsu_req_i.size != LSU_SIZE_W ||
                      !amo_known(lsu_req_i.amo));
    assign req_err = out_of_range || misaligned || amo_bad;

    lsu_amo_alu u_amo_alu (
        .op      (amo_q),
        .old_val (sram_rdata_i),
        .operand (wdata_q),
        .result  (amo_result)
    );

    // SRAM port is driven in the request cycle; reset gates it to idle
    always_comb begin
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_be_o    = 4'h0;
        sram_addr_o  = '0;
        sram_wdata_o = 32'h0;
        if (rst_ni) begin
            case (state)
                ST_IDLE: begin
                    if (lsu_req_i.req && !req_err) begin
                        sram_en_o   = 1'b1;
                        sram_addr_o = word_addr;
                        if (!is_amo && lsu_req_i.we) begin
                            sram_we_o    = 1'b1;
                            sram_be_o    = lsu_req_i.strb;
                            sram_wdata_o = lsu_req_i.wdata;
                        end
                    end
                end
                ST_AMO_WR: begin
                    sram_en_o    = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_be_o    = 4'hF;
                    sram_addr_o  = addr_q;
                    sram_wdata_o = amo_result;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            amo_q   <= AMO_NONE;
            wdata_q <= 32'h0;
            addr_q  <= '0;
            old_q   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lsu_req_i.req) begin
                        err_q  <= req_err;
                        load_q <= !req_err && !is_amo && !lsu_req_i.we;
                        if (req_err || !is_amo) begin
                            state <= ST_RESP;
                        end else begin
                            state   <= ST_AMO_WR;
                            amo_q   <= lsu_amo_e'(lsu_req_i.amo);
                            wdata_q <= lsu_req_i.wdata;
                            addr_q  <= word_addr;
                        end
                    end
                end
                ST_AMO_WR: begin
                    old_q <= sram_rdata_i;
                    state <= ST_AMO_ACK;
                end
                ST_RESP: begin
                    err_q  <= 1'b0;
                    load_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_AMO_ACK: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Load data comes straight from the SRAM read port in the ack cycle
    always_comb begin
        lsu_ack_o = '0;
        case (state)
            ST_RESP: begin
                lsu_ack_o.ack   = 1'b1;
                lsu_ack_o.error = err_q;
                lsu_ack_o.rdata = load_q ? sram_rdata_i : 32'h0;
            end
            ST_AMO_ACK: begin
                lsu_ack_o.ack   = 1'b1;
                lsu_ack_o.rdata = old_q;
            end
            default: ;
        endcase
    end

endmodule
